// File: rtl/dir_step_ctrl.sv
// dir_step_ctrl
// Movement sequencer behind the keyboard direction decoder. Resolves the
// held-direction mask into a single direction, issues step commands over a
// valid/ready handshake with typematic repeat timing (first step on press,
// a longer first delay, then periodic repeats counted in game ticks), and
// tracks the saturating player position on a bounded grid.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   tick        one-cycle game-tick strobe
//   nums        held-direction mask: [3] up, [2] down, [1] left, [0] right
//   step_ready  consumer accepts the pending step this cycle
//   step_valid  step command pending
//   step_dir    step direction: 00 up, 01 down, 10 left, 11 right
//   pos_x       current x coordinate (0..X_MAX)
//   pos_y       current y coordinate (0..Y_MAX)

module dir_step_ctrl #(
  parameter int unsigned X_MAX        = 15,
  parameter int unsigned Y_MAX        = 11,
  parameter int unsigned XW           = 4,
  parameter int unsigned YW           = 4,
  parameter int unsigned X_INIT       = 0,
  parameter int unsigned Y_INIT       = 0,
  parameter int unsigned DELAY_TICKS  = 8,
  parameter int unsigned REPEAT_TICKS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [3:0]    nums,
  input  logic          step_ready,
  output logic          step_valid,
  output logic [1:0]    step_dir,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y
);

  localparam int unsigned CntMax = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  localparam logic [CW-1:0] CntDelay  = CW'(DELAY_TICKS);
  localparam logic [CW-1:0] CntRepeat = CW'(REPEAT_TICKS);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  localparam logic [XW-1:0] XMax  = XW'(X_MAX);
  localparam logic [XW-1:0] XInit = XW'(X_INIT);
  localparam logic [YW-1:0] YMax  = YW'(Y_MAX);
  localparam logic [YW-1:0] YInit = YW'(Y_INIT);

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirRight = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StHold
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cur_dir_q, cur_dir_d;
  logic          first_q, first_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;

  logic       up_eff, down_eff, left_eff, right_eff;
  logic       req_valid;
  logic [1:0] dir_req;
  logic       accept;

  // Direction resolution: opposing keys on one axis cancel that axis, then
  // fixed priority up > down > left > right picks the request.
  always_comb begin
    up_eff    = nums[3] & ~nums[2];
    down_eff  = nums[2] & ~nums[3];
    left_eff  = nums[1] & ~nums[0];
    right_eff = nums[0] & ~nums[1];
    req_valid = up_eff | down_eff | left_eff | right_eff;
    dir_req   = DirUp;
    if (up_eff) begin
      dir_req = DirUp;
    end else if (down_eff) begin
      dir_req = DirDown;
    end else if (left_eff) begin
      dir_req = DirLeft;
    end else if (right_eff) begin
      dir_req = DirRight;
    end
  end

  assign accept = (state_q == StIssue) & step_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latched direction, first-step flag, tick counter, position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_dir_q <= DirUp;
      first_q   <= 1'b1;
      cnt_q     <= '0;
      pos_x_q   <= XInit;
      pos_y_q   <= YInit;
    end else begin
      cur_dir_q <= cur_dir_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
    end
  end

  // Next-state and sequencing control.
  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cur_dir_d = dir_req;
          first_d   = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        // Direction is frozen here; nums is not looked at until HOLD.
        if (accept) begin
          cnt_d   = first_q ? CntDelay : CntRepeat;
          state_d = StHold;
        end
      end
      StHold: begin
        if (!req_valid) begin
          state_d = StIdle;
        end else if (dir_req != cur_dir_q) begin
          // A new direction steps immediately and restarts the first delay.
          cur_dir_d = dir_req;
          first_d   = 1'b1;
          state_d   = StIssue;
        end else if (tick && (cnt_q == CntOne)) begin
          first_d = 1'b0;
          state_d = StIssue;
        end else if (tick && (cnt_q != '0)) begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating position update on the accepting edge; a step into a wall
  // is still handshaked but leaves the coordinate unchanged.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (accept) begin
      unique case (cur_dir_q)
        DirUp: begin
          if (pos_y_q != '0) pos_y_d = pos_y_q - YW'(1);
        end
        DirDown: begin
          if (pos_y_q < YMax) pos_y_d = pos_y_q + YW'(1);
        end
        DirLeft: begin
          if (pos_x_q != '0) pos_x_d = pos_x_q - XW'(1);
        end
        DirRight: begin
          if (pos_x_q < XMax) pos_x_d = pos_x_q + XW'(1);
        end
        default: begin
          pos_x_d = pos_x_q;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    step_valid = (state_q == StIssue);
    step_dir   = cur_dir_q;
    pos_x      = pos_x_q;
    pos_y      = pos_y_q;
  end

endmodule

// File: tb/tb_dir_step_ctrl.sv
// Directed self-checking bench for dir_step_ctrl (default parameters).
module tb_dir_step_ctrl;

  localparam int Delay  = 8;
  localparam int Repeat = 3;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] nums;
  logic       step_ready;
  logic       step_valid;
  logic [1:0] step_dir;
  logic [3:0] pos_x;
  logic [3:0] pos_y;

  int checks;
  int failures;
  int hs_cnt;
  int hs_base;

  dir_step_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .nums       (nums),
    .step_ready (step_ready),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .pos_x      (pos_x),
    .pos_y      (pos_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counter, sampled on the active edge with pre-edge values.
  initial hs_cnt = 0;
  always @(posedge clk) begin
    if (rst && step_valid && step_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_rep(input int k);
    return (k == Delay) || (k > Delay && ((k - Delay) % Repeat) == 0);
  endfunction

  // Press and hold a mask with step_ready=1, pulsing tick every 4th cycle.
  task automatic run_hold(input logic [3:0] n, input int nticks, input string tag);
    nums = n;
    tick = 1'b0;
    step_ready = 1'b1;
    cycle();
    check_eq({tag, "_press_valid"}, int'(step_valid), 1);
    cycle();
    for (int k = 1; k <= nticks; k++) begin
      repeat (3) cycle();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      check_eq($sformatf("%s_tick%0d_valid", tag, k), int'(step_valid), int'(is_rep(k)));
    end
    cycle();
    nums = 4'b0000;
    cycle();
    cycle();
    check_eq({tag, "_idle"}, int'(step_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    tick       = 1'b0;
    nums       = 4'b1000;
    step_ready = 1'b0;

    // Reset state while up is held.
    repeat (3) cycle();
    check_eq("rst_valid", int'(step_valid), 0);
    check_eq("rst_dir", int'(step_dir), 0);
    check_eq("rst_x", int'(pos_x), 0);
    check_eq("rst_y", int'(pos_y), 0);
    rst = 1'b1;
    cycle();
    check_eq("rel_valid", int'(step_valid), 1);
    check_eq("rel_dir", int'(step_dir), 0);
    nums = 4'b0000;
    step_ready = 1'b1;
    cycle();
    check_eq("up_wall_y", int'(pos_y), 0);
    check_eq("up_wall_valid", int'(step_valid), 0);
    cycle();

    // Single tap right.
    hs_base = hs_cnt;
    nums = 4'b0001;
    cycle();
    check_eq("tap_valid", int'(step_valid), 1);
    check_eq("tap_dir", int'(step_dir), 3);
    cycle();
    nums = 4'b0000;
    check_eq("tap_x", int'(pos_x), 1);
    check_eq("tap_y", int'(pos_y), 0);
    repeat (3) cycle();
    check_eq("tap_idle", int'(step_valid), 0);
    check_eq("tap_hs", hs_cnt - hs_base, 1);

    // Hold down: steps on press and at ticks 8, 11, 14.
    hs_base = hs_cnt;
    run_hold(4'b0100, 14, "hold");
    check_eq("hold_hs", hs_cnt - hs_base, 4);
    check_eq("hold_y", int'(pos_y), 4);
    check_eq("hold_x", int'(pos_x), 1);

    // Conflict resolution.
    step_ready = 1'b0;
    nums = 4'b1100;
    repeat (3) cycle();
    check_eq("ud_cancel", int'(step_valid), 0);
    nums = 4'b1110;
    cycle();
    check_eq("udl_valid", int'(step_valid), 1);
    check_eq("udl_dir", int'(step_dir), 2);
    nums = 4'b1010;
    cycle();
    check_eq("frozen_dir", int'(step_dir), 2);
    nums = 4'b0000;
    step_ready = 1'b1;
    cycle();
    check_eq("left_x", int'(pos_x), 0);
    cycle();
    step_ready = 1'b0;
    nums = 4'b1010;
    cycle();
    check_eq("ul_valid", int'(step_valid), 1);
    check_eq("ul_dir", int'(step_dir), 0);
    nums = 4'b0000;
    step_ready = 1'b1;
    cycle();
    cycle();
    check_eq("ul_y", int'(pos_y), 3);

    // Left wall from (0,0): four handshakes, x stays 0.
    do_reset();
    check_eq("rst2_y", int'(pos_y), 0);
    hs_base = hs_cnt;
    run_hold(4'b0010, 14, "lwall");
    check_eq("lwall_hs", hs_cnt - hs_base, 4);
    check_eq("lwall_x", int'(pos_x), 0);

    // Walk to (15,11), then press right into the wall.
    run_hold(4'b0001, 50, "walk_r");
    check_eq("walk_x", int'(pos_x), 15);
    run_hold(4'b0100, 38, "walk_d");
    check_eq("walk_y", int'(pos_y), 11);
    hs_base = hs_cnt;
    nums = 4'b0001;
    cycle();
    check_eq("rwall_dir", int'(step_dir), 3);
    cycle();
    nums = 4'b0000;
    cycle();
    cycle();
    check_eq("rwall_hs", hs_cnt - hs_base, 1);
    check_eq("rwall_x", int'(pos_x), 15);
    check_eq("rwall_y", int'(pos_y), 11);

    // Backpressure: direction frozen while nums changes.
    do_reset();
    step_ready = 1'b0;
    nums = 4'b0001;
    cycle();
    nums = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq($sformatf("bp%0d_dir", i), int'(step_dir), 3);
      check_eq($sformatf("bp%0d_x", i), int'(pos_x), 0);
    end
    check_eq("bp_valid", int'(step_valid), 1);
    nums = 4'b0000;
    step_ready = 1'b1;
    cycle();
    check_eq("bp_acc_x", int'(pos_x), 1);
    cycle();

    // Asynchronous reset mid-ISSUE.
    step_ready = 1'b0;
    nums = 4'b0001;
    cycle();
    check_eq("mid_valid", int'(step_valid), 1);
    rst = 1'b0;
    #1;
    check_eq("arst_valid", int'(step_valid), 0);
    check_eq("arst_x", int'(pos_x), 0);
    step_ready = 1'b1;
    cycle();
    check_eq("arst_hold_x", int'(pos_x), 0);
    check_eq("arst_hold_valid", int'(step_valid), 0);
    nums = 4'b0000;
    rst = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
